// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, register IDs.
// Also holds the pipe-control state type and the hazard bundle.
package y86_pkg;

    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPOPQ   = 4'd11;

    localparam logic [3:0] RNONE   = 4'd15;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } run_state_t;

    typedef struct packed {
        logic load_use;
        logic ret_any;
        logic mispred;
        logic exc;
    } hazard_t;

    function automatic logic is_load(input logic [3:0] icode);
        return (icode == IMRMOVQ) || (icode == IPOPQ);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: count visible one clock after inc is sampled.
// Backpressure: none; inc is a plain per-cycle enable.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: per-stage stall/bubble, run/halt FSM, perf counters.
// Latency: hazard outputs are combinational; halted follows a bad W_stat by one clock.
// Backpressure: stalls hold F/D/W, bubbles squash D/E/M; STOP freezes the whole pipe.
module pipe_ctrl #(
    parameter int         CNT_W = 32,
    parameter logic [3:0] RNONE = 4'd15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [1:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    import y86_pkg::*;

    hazard_t    hz;
    run_state_t state;
    logic       w_exc;
    logic       in_run;
    logic       run_ok;

    assign hz.load_use = is_load(E_icode) && (E_dstM != RNONE) &&
                         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign hz.ret_any  = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    assign hz.mispred  = (E_icode == IJXX) && !e_Cnd;
    assign w_exc       = (W_stat != STAT_AOK);
    assign hz.exc      = (m_stat != STAT_AOK) || w_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            final_stat <= STAT_AOK;
        end else if ((state == RUN) && w_exc) begin
            state      <= STOP;
            final_stat <= W_stat;
        end
    end

    assign halted = (state == STOP);
    assign in_run = (state == RUN);

    // The retiring edge into STOP still counts as a RUN cycle, but no hazard events.
    assign run_ok = in_run && !w_exc;

    always_comb begin
        F_stall  = hz.load_use | hz.ret_any;
        D_stall  = hz.load_use;
        D_bubble = hz.mispred | (hz.ret_any & ~hz.load_use);
        E_bubble = hz.mispred | hz.load_use;
        M_bubble = hz.exc;
        W_stall  = w_exc;
        set_cc   = (E_icode == IOPQ) && !hz.exc;
        if (!rst_n) begin
            F_stall  = 1'b0;
            D_stall  = 1'b0;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b0;
            set_cc   = 1'b0;
        end else if (state == STOP) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            D_bubble = 1'b0;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
            W_stall  = 1'b1;
            set_cc   = 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cyc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_run),
        .cnt   (cyc_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lu (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (run_ok & hz.load_use),
        .cnt   (lu_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (run_ok & hz.mispred),
        .cnt   (mp_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (run_ok & hz.ret_any & ~hz.load_use),
        .cnt   (ret_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, directed corner sequences, random stream vs reference model.
module tb_pipe_ctrl;

    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic             e_Cnd;
    logic [1:0]       m_stat, W_stat;
    logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [1:0]       final_stat;
    logic [CNT_W-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    pipe_ctrl #(.CNT_W(CNT_W), .RNONE(4'd15)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .halted(halted), .final_stat(final_stat),
        .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    typedef struct {
        logic [3:0] d_ic, sa, sb, e_ic, e_dst;
        logic       cnd;
        logic [3:0] m_ic;
        logic [1:0] ms, ws;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp;   // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: architectural state of the controller
    bit m_stop;
    int m_fstat, m_cyc, m_lu, m_mp, m_ret;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic in_t mk(input int d, input int sa, input int sb, input int e,
                               input int ed, input int c, input int m, input int ms, input int ws);
        in_t v;
        v.d_ic = 4'(d); v.sa = 4'(sa); v.sb = 4'(sb); v.e_ic = 4'(e); v.e_dst = 4'(ed);
        v.cnd = 1'(c); v.m_ic = 4'(m); v.ms = 2'(ms); v.ws = 2'(ws);
        return v;
    endfunction

    function automatic in_t nop_in();
        return mk(1, 15, 15, 1, 15, 1, 1, 0, 0);
    endfunction

    task automatic apply(input in_t v);
        D_icode = v.d_ic; d_srcA = v.sa; d_srcB = v.sb; E_icode = v.e_ic;
        E_dstM = v.e_dst; e_Cnd = v.cnd; M_icode = v.m_ic; m_stat = v.ms; W_stat = v.ws;
    endtask

    function automatic int sat_inc(input int x);
        return (x >= MAXC) ? MAXC : x + 1;
    endfunction

    task automatic model_reset();
        m_stop = 0; m_fstat = 0; m_cyc = 0; m_lu = 0; m_mp = 0; m_ret = 0;
    endtask

    task automatic hazards(output bit lu, output bit ra, output bit mp, output bit ex);
        lu = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'd15 &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
        ra = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
        mp = (E_icode == 4'd7) && !e_Cnd;
        ex = (m_stat != 2'd0) || (W_stat != 2'd0);
    endtask

    task automatic check_outputs(input string tag);
        bit lu, ra, mp, ex;
        logic [6:0] e;
        hazards(lu, ra, mp, ex);
        if (!rst_n)      e = 7'b0011100;
        else if (m_stop) e = 7'b1101110;
        else e = {lu | ra, lu, mp | (ra & ~lu), mp | lu, ex, W_stat != 2'd0,
                  (E_icode == 4'd6) && !ex};
        chk({tag, " F_stall"},  F_stall,  e[6]);
        chk({tag, " D_stall"},  D_stall,  e[5]);
        chk({tag, " D_bubble"}, D_bubble, e[4]);
        chk({tag, " E_bubble"}, E_bubble, e[3]);
        chk({tag, " M_bubble"}, M_bubble, e[2]);
        chk({tag, " W_stall"},  W_stall,  e[1]);
        chk({tag, " set_cc"},   set_cc,   e[0]);
        chk({tag, " halted"},   halted,   m_stop);
        chk({tag, " final_stat"}, final_stat, m_fstat);
        chk({tag, " cyc_cnt"},  cyc_cnt,  m_cyc);
        chk({tag, " lu_cnt"},   lu_cnt,   m_lu);
        chk({tag, " mp_cnt"},   mp_cnt,   m_mp);
        chk({tag, " ret_cnt"},  ret_cnt,  m_ret);
    endtask

    // One clock: model absorbs the sampled inputs, then return at the falling edge.
    task automatic tick();
        bit lu, ra, mp, ex;
        @(posedge clk);
        hazards(lu, ra, mp, ex);
        if (rst_n && !m_stop) begin
            m_cyc = sat_inc(m_cyc);
            if (W_stat != 2'd0) begin
                m_stop  = 1;
                m_fstat = W_stat;
            end else begin
                if (lu)        m_lu  = sat_inc(m_lu);
                if (mp)        m_mp  = sat_inc(m_mp);
                if (ra && !lu) m_ret = sat_inc(m_ret);
            end
        end
        @(negedge clk);
    endtask

    // Step one cycle with given inputs: apply, check combinational view, clock.
    task automatic step(input in_t v, input string tag);
        apply(v);
        #2;
        check_outputs(tag);
        tick();
    endtask

    // Mid-cycle asynchronous reset, held across one edge, released at a falling edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs({tag, " in_rst"});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs({tag, " released"});
    endtask

    vec_t vecs[12];
    logic [3:0] icodes[8];

    initial begin
        int b, cstop, stop_cycles;
        in_t v;

        vecs[0]  = '{mk(1, 15, 15, 1, 15, 1, 1, 0, 0), 7'b0000000};  // idle
        vecs[1]  = '{mk(6, 3, 15, 5, 3, 1, 1, 0, 0),   7'b1101000};  // mrmovq load-use srcA
        vecs[2]  = '{mk(6, 2, 4, 11, 4, 1, 1, 0, 0),   7'b1101000};  // popq load-use srcB
        vecs[3]  = '{mk(6, 15, 15, 5, 15, 1, 1, 0, 0), 7'b0000000};  // dstM none vs srcs none
        vecs[4]  = '{mk(6, 1, 2, 5, 3, 1, 1, 0, 0),    7'b0000000};  // load, no match
        vecs[5]  = '{mk(6, 15, 15, 7, 15, 0, 1, 0, 0), 7'b0011000};  // mispredict
        vecs[6]  = '{mk(6, 15, 15, 7, 15, 1, 1, 0, 0), 7'b0000000};  // jump taken
        vecs[7]  = '{mk(1, 15, 15, 6, 15, 1, 1, 0, 0), 7'b0000001};  // opq sets cc
        vecs[8]  = '{mk(9, 15, 15, 1, 15, 1, 1, 0, 0), 7'b1010000};  // ret in D
        vecs[9]  = '{mk(1, 15, 15, 1, 15, 1, 9, 0, 0), 7'b1010000};  // ret in M
        vecs[10] = '{mk(9, 3, 15, 5, 3, 1, 1, 0, 0),   7'b1101000};  // ret in D + load-use
        vecs[11] = '{mk(1, 15, 15, 6, 15, 1, 1, 2, 0), 7'b0000100};  // mem exception blocks cc

        icodes[0] = 4'd0; icodes[1] = 4'd1; icodes[2] = 4'd2; icodes[3] = 4'd5;
        icodes[4] = 4'd6; icodes[5] = 4'd7; icodes[6] = 4'd9; icodes[7] = 4'd11;

        rst_n = 1'b0;
        apply(nop_in());
        model_reset();
        @(negedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].in);
            #2;
            chk($sformatf("vec%0d outputs", i),
                {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}, vecs[i].exp);
            check_outputs($sformatf("vec%0d", i));
            tick();
        end

        b = m_lu;
        step(mk(6, 3, 15, 5, 3, 1, 1, 0, 0), "lu_seq");
        chk("lu_seq lu_cnt step", lu_cnt, b + 1);

        b = m_mp;
        step(mk(6, 15, 15, 7, 15, 0, 1, 0, 0), "mp_seq");
        chk("mp_seq mp_cnt step", mp_cnt, b + 1);

        b = m_ret;
        for (int i = 0; i < 3; i++) begin
            apply(mk(9, 15, 15, 1, 15, 1, 1, 0, 0));
            #2;
            chk($sformatf("ret_d%0d F_stall", i), F_stall, 1);
            chk($sformatf("ret_d%0d D_bubble", i), D_bubble, 1);
            tick();
        end
        chk("ret_seq ret_cnt 3", ret_cnt, b + 3);
        step(mk(1, 15, 15, 9, 15, 1, 1, 0, 0), "ret_e");
        step(mk(1, 15, 15, 1, 15, 1, 9, 0, 0), "ret_m");

        b = m_ret;
        step(mk(9, 3, 15, 5, 3, 1, 1, 0, 0), "ret_lu");
        chk("ret_lu ret_cnt held", ret_cnt, b);

        apply(mk(1, 15, 15, 6, 15, 1, 1, 2, 0));
        #2;
        chk("exc set_cc", set_cc, 0);
        chk("exc M_bubble", M_bubble, 1);
        tick();
        apply(mk(1, 15, 15, 6, 15, 1, 1, 0, 2));
        #2;
        chk("exc W_stall", W_stall, 1);
        chk("exc not yet halted", halted, 0);
        b = m_lu;
        cstop = m_cyc + 1;
        tick();
        apply(mk(6, 3, 15, 5, 3, 0, 9, 0, 0));
        #2;
        chk("stop halted", halted, 1);
        chk("stop final_stat", final_stat, 2);
        chk("stop cyc_cnt", cyc_cnt, cstop);
        chk("stop lu_cnt", lu_cnt, b);
        check_outputs("stop");
        tick();
        step(mk(6, 3, 15, 7, 3, 0, 9, 1, 0), "stop2");
        chk("stop cyc frozen", cyc_cnt, cstop);

        do_reset("rst_stop");
        chk("rst_stop halted", halted, 0);

        stop_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            v.d_ic  = icodes[$urandom_range(0, 7)];
            v.e_ic  = icodes[$urandom_range(0, 7)];
            v.m_ic  = icodes[$urandom_range(0, 7)];
            v.sa    = 4'($urandom_range(0, 15));
            v.sb    = 4'($urandom_range(0, 15));
            v.e_dst = 4'($urandom_range(0, 15));
            v.cnd   = 1'($urandom_range(0, 1));
            v.ms    = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.ws    = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            step(v, "rand");
            stop_cycles = m_stop ? stop_cycles + 1 : 0;
            if (stop_cycles >= 3) begin
                do_reset("rand");
                stop_cycles = 0;
            end
        end

        do_reset("sat");
        for (int i = 0; i < MAXC + 4; i++) begin
            step(mk(6, 3, 15, 5, 3, 1, 1, 0, 0), "sat");
        end
        chk("sat cyc_cnt", cyc_cnt, MAXC);
        chk("sat lu_cnt", lu_cnt, MAXC);
        step(nop_in(), "sat_hold");
        chk("sat cyc_cnt hold", cyc_cnt, MAXC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 core.
- Observes D/E/M/W stage state and generates the per-stage stall and bubble signals, plus the execute stage's set_cc and M_bubble inputs.
- Owns a run/halt state machine that freezes the pipe once a non-AOK status retires.
- Keeps saturating performance counters for cycles, load-use stalls, mispredicts and ret stalls.

Parameters:
- CNT_W, 32, width of each performance counter.
- RNONE, 4'd15, register ID meaning "no register".

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- D_icode  in  4  icode in decode register
- d_srcA  in  4  decode source A (RNONE if unused)
- d_srcB  in  4  decode source B (RNONE if unused)
- E_icode  in  4  icode in execute register
- E_dstM  in  4  execute-stage memory destination
- e_Cnd  in  1  condition result from execute stage
- M_icode  in  4  icode in memory register
- m_stat  in  2  status produced by memory stage
- W_stat  in  2  status in writeback register
- F_stall  out  1  hold fetch PC register
- D_stall  out  1  hold decode register
- D_bubble  out  1  inject nop into decode register
- E_bubble  out  1  inject nop into execute register
- M_bubble  out  1  inject nop into memory register
- W_stall  out  1  hold writeback register
- set_cc  out  1  enable condition-code update in execute
- halted  out  1  pipe frozen
- final_stat  out  2  status that caused the freeze
- cyc_cnt  out  CNT_W  cycles spent in RUN
- lu_cnt  out  CNT_W  load-use stall cycles
- mp_cnt  out  CNT_W  mispredict cycles
- ret_cnt  out  CNT_W  ret stall cycles

Behaviour:
- Status encoding: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- Hazard terms (combinational):
  - load_use = E_icode in {5 mrmovq, 11 popq} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB)
  - ret_any = 9 in {D_icode, E_icode, M_icode}
  - mispred = E_icode==7 && !e_Cnd
  - exc = m_stat!=AOK || W_stat!=AOK
- Outputs in RUN:
  - F_stall = load_use | ret_any
  - D_stall = load_use
  - D_bubble = mispred | (ret_any & ~load_use)
  - E_bubble = mispred | load_use
  - M_bubble = exc
  - W_stall = W_stat!=AOK
  - set_cc = E_icode==6 && !exc
- Priority: load_use with ret_any stalls D (no bubble). mispred together with load_use cannot co-occur in a legal stream; if it does, both E_bubble and D_bubble assert.
- States RUN and STOP, 1 flop, reset value RUN.
  - RUN->STOP on the clock edge where W_stat!=AOK; final_stat <= W_stat on that edge.
  - STOP is absorbing until reset.
- Outputs in STOP: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, D_bubble=0, set_cc=0, halted=1.
- While rst_n low, outputs are forced asynchronously: all stalls 0, D/E/M_bubble=1, set_cc=0, halted=0, final_stat=AOK, counters 0. Reset mid-operation returns to RUN on the first edge after release.
- Counters update on posedge only in RUN, saturating at all-ones (no wrap):
  - cyc_cnt +1 every RUN cycle.
  - lu_cnt +1 when load_use.
  - mp_cnt +1 when mispred.
  - ret_cnt +1 when ret_any & ~load_use.
- The counters do not increment on the transition edge into STOP beyond cyc_cnt.
- Latency: hazard outputs are zero-cycle combinational. halted asserts one cycle after W_stat!=AOK is sampled.

Decomposition:
- Shared package y86_pkg: icode constants (INOP 1, IRRMOVQ 2, IMRMOVQ 5, IOPQ 6, IJXX 7, IRET 9, IPOPQ 11), stat codes, RNONE.
- One sub-module, sat_counter (CNT_W width, inc, clear via rst_n), instantiated four times.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt 0->1 next edge.
- Mispredict: E_icode=7, e_Cnd=0, D_icode=6 -> D_bubble=1, E_bubble=1, F_stall=0; mp_cnt increments.
- Ret: D_icode=9 held for 3 cycles, then E, then M -> F_stall=1 and D_bubble=1 for all 3 cycles; ret_cnt=3.
- Ret in D with load_use on D's sources -> D_stall=1, D_bubble=0, ret_cnt unchanged.
- Exception: E_icode=6, m_stat=2 -> set_cc=0, M_bubble=1. Next W_stat=2 -> W_stall=1. Next edge: halted=1, final_stat=2, cyc_cnt frozen.
- Reset in STOP: rst_n low mid-cycle -> outputs forced immediately, counters 0. After release: RUN, halted=0. Also drive cyc_cnt to all-ones via force -> it stays all-ones next cycle.
